dcm_reset_ctrl: RTL and testbench

DCM_RESET_CTRL -- requirements
Module: dcm_reset_ctrl

---
 rtl/dcm_reset_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dcm_reset_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcm_reset_ctrl.sv
// dcm_reset_ctrl: sequences a DCM_SP through reset, lock acquisition and a
// stability window before releasing the reset of the logic it clocks.
// Failed attempts are retried up to a limit, after which the block parks
// in a fault state until restart_i or rst_i is asserted.
module dcm_reset_ctrl #(
    parameter int RST_HOLD_CYCLES = 8,
    parameter int LOCK_TIMEOUT    = 16384,
    parameter int STABLE_CYCLES   = 64,
    parameter int MAX_RETRIES     = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       dcm_locked_i,
    input  logic [7:0] dcm_status_i,
    input  logic       restart_i,
    output logic       dcm_rst_o,
    output logic       sys_rst_o,
    output logic       clk_ready_o,
    output logic       fault_o,
    output logic [7:0] retry_count_o
);

    typedef enum logic [2:0] {
        RESET_DCM,
        WAIT_LOCK,
        STABILISE,
        RUN,
        FAULT
    } state_t;

    // The shared counter must hold the largest terminal count of any state.
    localparam int MAX_AB    = (RST_HOLD_CYCLES > STABLE_CYCLES) ? RST_HOLD_CYCLES : STABLE_CYCLES;
    localparam int MAX_COUNT = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    // Bit 0 is LOCKED, bits 1 and 2 are the CLKIN/CLKFX stopped flags.
    logic [2:0] meta_q;
    logic [2:0] sync_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             dcmRst_q, sysRst_q, clkReady_q, fault_q;

    logic       locked;
    logic       bad;
    logic       failure;
    logic [7:0] retryInc;
    logic       retryLimit;
    logic       unusedStatusBits;

    assign unusedStatusBits = ^{dcm_status_i[7:3], dcm_status_i[0]};

    assign locked     = sync_q[0];
    assign bad        = sync_q[1] | sync_q[2];
    assign retryInc   = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
    assign retryLimit = (MAX_RETRIES != 0) && (int'(retryInc) >= MAX_RETRIES);

    // Two-flop synchronisers bring the asynchronous DCM flags into clk_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 3'b000;
            sync_q <= 3'b000;
        end else begin
            meta_q <= {dcm_status_i[2], dcm_status_i[1], dcm_locked_i};
            sync_q <= meta_q;
        end
    end

    // Next-state, counter and retry bookkeeping; restart overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        failure = 1'b0;
        if (restart_i) begin
            state_d = RESET_DCM;
            cnt_d   = '0;
            retry_d = 8'd0;
        end else begin
            case (state_q)
                RESET_DCM: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WAIT_LOCK: begin
                    if (locked && !bad) begin
                        state_d = STABILISE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        failure = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                STABILISE: begin
                    if (!locked || bad) begin
                        failure = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    if (!locked || bad) begin
                        failure = 1'b1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = RESET_DCM;
                    cnt_d   = '0;
                end
            endcase
            if (failure) begin
                retry_d = retryInc;
                state_d = retryLimit ? FAULT : RESET_DCM;
                cnt_d   = '0;
            end
        end
    end

    // State register; outputs are decoded from the next state so they switch on the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= RESET_DCM;
            cnt_q      <= '0;
            retry_q    <= 8'd0;
            dcmRst_q   <= 1'b1;
            sysRst_q   <= 1'b1;
            clkReady_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            dcmRst_q   <= (state_d == RESET_DCM) || (state_d == FAULT);
            sysRst_q   <= (state_d != RUN);
            clkReady_q <= (state_d == RUN);
            fault_q    <= (state_d == FAULT);
        end
    end

    assign dcm_rst_o     = dcmRst_q;
    assign sys_rst_o     = sysRst_q;
    assign clk_ready_o   = clkReady_q;
    assign fault_o       = fault_q;
    assign retry_count_o = retry_q;

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// tb_dcm_reset_ctrl: directed scenarios with hand-computed expectations,
// followed by randomized lock/status/restart/reset traffic, all checked
// every cycle against a behavioural model of the reset sequencer.
module tb_dcm_reset_ctrl;

    localparam int RST_HOLD = 4;
    localparam int TIMEOUT  = 20;
    localparam int STABLE   = 8;
    localparam int MAXR     = 3;

    localparam int PH_HOLD   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_UP     = 3;
    localparam int PH_DEAD   = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       dcm_locked_i = 1'b0;
    logic [7:0] dcm_status_i = 8'h00;
    logic       restart_i = 1'b0;
    logic       dcm_rst_o;
    logic       sys_rst_o;
    logic       clk_ready_o;
    logic       fault_o;
    logic [7:0] retry_count_o;

    int total = 0;
    int bad = 0;
    bit cmpEn = 1'b0;

    int mPhase = PH_HOLD;
    int mElapsed = 0;
    int mRetries = 0;
    bit lockPipe[$];
    bit badPipe[$];
    bit seenLock, seenBad, good, failed;

    dcm_reset_ctrl #(
        .RST_HOLD_CYCLES(RST_HOLD),
        .LOCK_TIMEOUT(TIMEOUT),
        .STABLE_CYCLES(STABLE),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .dcm_locked_i(dcm_locked_i),
        .dcm_status_i(dcm_status_i),
        .restart_i(restart_i),
        .dcm_rst_o(dcm_rst_o),
        .sys_rst_o(sys_rst_o),
        .clk_ready_o(clk_ready_o),
        .fault_o(fault_o),
        .retry_count_o(retry_count_o)
    );

    // Free-running reference clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic lk, input logic [7:0] st, input logic rs);
        dcm_locked_i = lk;
        dcm_status_i = st;
        restart_i    = rs;
    endtask

    task automatic modelReset();
        mPhase   = PH_HOLD;
        mElapsed = 0;
        mRetries = 0;
        lockPipe.delete();
        badPipe.delete();
        lockPipe.push_back(1'b0);
        lockPipe.push_back(1'b0);
        badPipe.push_back(1'b0);
        badPipe.push_back(1'b0);
    endtask

    // Behavioural model: inputs reach the sequencer two edges late; each phase
    // counts completed cycles and a failure either retries or gives up.
    initial begin
        modelReset();
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                modelReset();
            end else begin
                seenLock = lockPipe.pop_front();
                seenBad  = badPipe.pop_front();
                lockPipe.push_back(dcm_locked_i);
                badPipe.push_back(dcm_status_i[1] | dcm_status_i[2]);
                good   = seenLock && !seenBad;
                failed = 1'b0;
                if (restart_i) begin
                    mPhase   = PH_HOLD;
                    mElapsed = 0;
                    mRetries = 0;
                end else begin
                    case (mPhase)
                        PH_HOLD: begin
                            mElapsed++;
                            if (mElapsed == RST_HOLD) begin
                                mPhase   = PH_WAIT;
                                mElapsed = 0;
                            end
                        end
                        PH_WAIT: begin
                            if (good) begin
                                mPhase   = PH_SETTLE;
                                mElapsed = 0;
                            end else begin
                                mElapsed++;
                                if (mElapsed == TIMEOUT) failed = 1'b1;
                            end
                        end
                        PH_SETTLE: begin
                            if (!good) begin
                                failed = 1'b1;
                            end else begin
                                mElapsed++;
                                if (mElapsed == STABLE) begin
                                    mPhase   = PH_UP;
                                    mElapsed = 0;
                                end
                            end
                        end
                        PH_UP: begin
                            if (!good) failed = 1'b1;
                        end
                        default: ;
                    endcase
                    if (failed) begin
                        mRetries = (mRetries < 255) ? mRetries + 1 : 255;
                        mPhase   = (MAXR != 0 && mRetries >= MAXR) ? PH_DEAD : PH_HOLD;
                        mElapsed = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (cmpEn) begin
                checkOutput("model dcm_rst", dcm_rst_o, (mPhase == PH_HOLD) || (mPhase == PH_DEAD));
                checkOutput("model sys_rst", sys_rst_o, mPhase != PH_UP);
                checkOutput("model clk_ready", clk_ready_o, mPhase == PH_UP);
                checkOutput("model fault", fault_o, mPhase == PH_DEAD);
                checkOutput("model retry", retry_count_o, mRetries);
            end
        end
    end

    // Holds reset for a few cycles and releases it on a falling edge with the given lock level.
    task automatic doReset(input logic lockAfter);
        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        dcm_locked_i = lockAfter;
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        cmpEn = 1'b1;

        // Clean power-up with lock present from the start, then a CLKFX-stopped event in RUN.
        doReset(1'b1);
        checkOutput("s029 dcm_rst c0", dcm_rst_o, 1);
        checkOutput("s029 sys_rst c0", sys_rst_o, 1);
        checkOutput("s029 clk_ready c0", clk_ready_o, 0);
        repeat (3) @(negedge clk_i);
        checkOutput("s029 dcm_rst c3", dcm_rst_o, 1);
        @(negedge clk_i);
        checkOutput("s029 dcm_rst c4", dcm_rst_o, 0);
        repeat (8) @(negedge clk_i);
        checkOutput("s029 clk_ready c12", clk_ready_o, 0);
        @(negedge clk_i);
        checkOutput("s029 clk_ready c13", clk_ready_o, 1);
        checkOutput("s029 sys_rst c13", sys_rst_o, 0);
        checkOutput("s029 retry c13", retry_count_o, 0);
        checkOutput("s029 model up c13", mPhase == PH_UP, 1);
        dcm_status_i = 8'h04;
        @(negedge clk_i);
        dcm_status_i = 8'h00;
        @(negedge clk_i);
        checkOutput("s032 clk_ready c15", clk_ready_o, 1);
        @(negedge clk_i);
        checkOutput("s032 sys_rst c16", sys_rst_o, 1);
        checkOutput("s032 clk_ready c16", clk_ready_o, 0);
        checkOutput("s032 dcm_rst c16", dcm_rst_o, 1);
        checkOutput("s032 retry c16", retry_count_o, 1);
        repeat (3) @(negedge clk_i);
        checkOutput("s032 dcm_rst c19", dcm_rst_o, 1);
        @(negedge clk_i);
        checkOutput("s032 dcm_rst c20", dcm_rst_o, 0);

        // One-cycle lock dropout that lands in the stability window.
        doReset(1'b1);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk_i);
            checkOutput("s031 clk_ready low", clk_ready_o, 0);
            if (k == 7) dcm_locked_i = 1'b0;
            if (k == 8) dcm_locked_i = 1'b1;
            if (k == 10) begin
                checkOutput("s031 retry c10", retry_count_o, 1);
                checkOutput("s031 dcm_rst c10", dcm_rst_o, 1);
            end
        end
        @(negedge clk_i);
        checkOutput("s031 clk_ready c23", clk_ready_o, 1);

        // No lock ever: three timeouts into FAULT, then a restart.
        doReset(1'b0);
        repeat (24) @(negedge clk_i);
        checkOutput("s030 retry c24", retry_count_o, 1);
        checkOutput("s030 dcm_rst c24", dcm_rst_o, 1);
        repeat (24) @(negedge clk_i);
        checkOutput("s030 retry c48", retry_count_o, 2);
        repeat (23) @(negedge clk_i);
        checkOutput("s030 fault c71", fault_o, 0);
        @(negedge clk_i);
        checkOutput("s030 fault c72", fault_o, 1);
        checkOutput("s030 retry c72", retry_count_o, 3);
        checkOutput("s030 model dead c72", mPhase == PH_DEAD, 1);
        repeat (8) @(negedge clk_i);
        checkOutput("s030 fault c80", fault_o, 1);
        checkOutput("s030 dcm_rst c80", dcm_rst_o, 1);
        checkOutput("s030 sys_rst c80", sys_rst_o, 1);
        restart_i = 1'b1;
        @(negedge clk_i);
        restart_i = 1'b0;
        checkOutput("s033 fault c81", fault_o, 0);
        checkOutput("s033 retry c81", retry_count_o, 0);
        checkOutput("s033 dcm_rst c81", dcm_rst_o, 1);
        repeat (3) @(negedge clk_i);
        checkOutput("s033 dcm_rst c84", dcm_rst_o, 1);
        @(negedge clk_i);
        checkOutput("s033 dcm_rst c85", dcm_rst_o, 0);

        // Asynchronous reset in the middle of the stability window.
        doReset(1'b1);
        repeat (7) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("s034 dcm_rst async", dcm_rst_o, 1);
        checkOutput("s034 sys_rst async", sys_rst_o, 1);
        checkOutput("s034 clk_ready async", clk_ready_o, 0);
        checkOutput("s034 fault async", fault_o, 0);
        checkOutput("s034 retry async", retry_count_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Randomized traffic: lock regimes change periodically, with rare status faults, restarts and resets.
        begin
            int lockMode;
            logic lk;
            logic [7:0] st;
            logic rs;
            lockMode = 1;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(negedge clk_i);
                if (cyc % 60 == 0) lockMode = $urandom_range(0, 3);
                lk = (lockMode == 0) ? 1'b0 : ($urandom_range(0, 79) != 0);
                st = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 39) != 0) st = st & 8'hF9;
                rs = ($urandom_range(0, 149) == 0);
                applyStimulus(lk, st, rs);
                if ($urandom_range(0, 499) == 0) begin
                    #2 rst_i = 1'b1;
                    @(negedge clk_i);
                    rst_i = 1'b0;
                end
            end
        end

        @(negedge clk_i);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk_i);
        cmpEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
